fft_bf_sequencer: RTL and testbench

Control sequencer for the 16-point radix-2 in-place FFT. On a start pulse it steps stage 0..3 and butterfly 0..7, drives the combinational read-address LUT, strobes the data-memory read, and delays the LUT's A/B addresses through a pipeline so each butterfly result is written back in place. A stage barrier drains the butterfly pipeline before the next stage reads, and a single-cycle done pulse ends the transform.

---
 rtl/fft_bf_sequencer.sv | 151 +++++++++++++++
 tb/tb_fft_bf_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bf_sequencer.sv
// Control sequencer for a 16-point radix-2 in-place FFT.
// Walks stage 0..3 and butterfly 0..7, issues one data-memory read per
// butterfly, and delays the LUT's A/B addresses so each result is written
// back in place BF_LATENCY cycles later. A drain phase after every stage
// keeps the next stage's reads behind the previous stage's writes.
module fft_bf_sequencer #(
    parameter int BF_LATENCY = 2 // read issue to write-back, legal 1..7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [1:0] stage,
    output logic [2:0] butterfly,
    input  logic [3:0] A_addr_in,
    input  logic [3:0] B_addr_in,
    output logic       rd_en,
    output logic       wr_en,
    output logic [3:0] wr_A_addr,
    output logic [3:0] wr_B_addr,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // One pending write-back: valid flag plus the in-place target addresses.
    typedef struct packed {
        logic       valid;
        logic [3:0] a_addr;
        logic [3:0] b_addr;
    } wb_slot_t;

    localparam logic [2:0] DRAIN_LOAD = 3'(BF_LATENCY);

    state_t     state_q, state_d;
    logic [1:0] stage_q, stage_d;
    logic [2:0] bf_q, bf_d;
    logic [2:0] drain_cnt_q, drain_cnt_d;

    wb_slot_t   line_q [BF_LATENCY];
    wb_slot_t   line_d [BF_LATENCY];

    // FSM and counter registers.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            stage_q     <= 2'd0;
            bf_q        <= 3'd0;
            drain_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            bf_q        <= bf_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state logic: issue 8 butterflies, drain the pipeline, repeat per stage.
    // NOTE: every signal gets its hold value before the case statement, so no
    // path through the block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        bf_d        = bf_q;
        drain_cnt_d = drain_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                stage_d = 2'd0;
                bf_d    = 3'd0;
                if (start) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bf_q == 3'd7) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end else begin
                    bf_d = bf_q + 3'd1;
                end
            end
            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q - 3'd1;
                if (drain_cnt_q == 3'd1) begin
                    if (stage_q == 2'd3) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        stage_d = stage_q + 2'd1;
                        bf_d    = 3'd0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                stage_d = 2'd0;
                bf_d    = 3'd0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Delay-line feed: capture the LUT addresses of the butterfly issued this
    // cycle; idle slots carry zero addresses so write outputs read 0 when idle.
    always_comb begin
        line_d[0].valid  = rd_en;
        line_d[0].a_addr = rd_en ? A_addr_in : 4'd0;
        line_d[0].b_addr = rd_en ? B_addr_in : 4'd0;
        for (int i = 1; i < BF_LATENCY; i++) begin
            line_d[i] = line_q[i-1];
        end
    end

    // Delay-line registers, free-running regardless of FSM state.
    // NOTE: this array is a shift register, not a RAM, so it is reset on
    // purpose: reset must discard every in-flight write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BF_LATENCY; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BF_LATENCY; i++) begin
                line_q[i] <= line_d[i];
            end
        end
    end

    // Output decode from registered state and the delay-line tail.
    always_comb begin
        stage     = stage_q;
        butterfly = bf_q;
        rd_en     = (state_q == ST_ISSUE);
        busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
        done      = (state_q == ST_DONE);
        wr_en     = line_q[BF_LATENCY-1].valid;
        wr_A_addr = line_q[BF_LATENCY-1].a_addr;
        wr_B_addr = line_q[BF_LATENCY-1].b_addr;
    end

endmodule

// File: tb/tb_fft_bf_sequencer.sv
// Self-checking bench for fft_bf_sequencer. Three instances (latency 1, 2
// and 7) run side by side from the same start/reset stimulus; each output
// trace is compared every cycle against a cycle-schedule model that derives
// reads, writes and done from run-relative cycle arithmetic.
module tb_fft_bf_sequencer;

    logic clk;
    logic rst;
    logic start;

    logic [1:0] stage_o     [3];
    logic [2:0] butterfly_o [3];
    logic [3:0] a_in        [3];
    logic [3:0] b_in        [3];
    logic       rd_en_o     [3];
    logic       wr_en_o     [3];
    logic [3:0] wr_a_o      [3];
    logic [3:0] wr_b_o      [3];
    logic       busy_o      [3];
    logic       done_o      [3];

    // Address LUT seen by the DUTs, indexed [stage][butterfly].
    logic [3:0] lut_a [4][8];
    logic [3:0] lut_b [4][8];

    int lat_v [3] = '{1, 2, 7};

    // Reference model state per instance: active run flag and run-relative cycle.
    bit act   [3];
    int k_cyc [3];

    int done_cnt [3];
    int done_1st [3];
    int done_2nd [3];
    int rel;

    int n_tests = 0;
    int n_fail  = 0;

    fft_bf_sequencer #(.BF_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .start(start),
        .stage(stage_o[0]), .butterfly(butterfly_o[0]),
        .A_addr_in(a_in[0]), .B_addr_in(b_in[0]),
        .rd_en(rd_en_o[0]), .wr_en(wr_en_o[0]),
        .wr_A_addr(wr_a_o[0]), .wr_B_addr(wr_b_o[0]),
        .busy(busy_o[0]), .done(done_o[0])
    );

    fft_bf_sequencer #(.BF_LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .start(start),
        .stage(stage_o[1]), .butterfly(butterfly_o[1]),
        .A_addr_in(a_in[1]), .B_addr_in(b_in[1]),
        .rd_en(rd_en_o[1]), .wr_en(wr_en_o[1]),
        .wr_A_addr(wr_a_o[1]), .wr_B_addr(wr_b_o[1]),
        .busy(busy_o[1]), .done(done_o[1])
    );

    fft_bf_sequencer #(.BF_LATENCY(7)) u_dut_l7 (
        .clk(clk), .rst(rst), .start(start),
        .stage(stage_o[2]), .butterfly(butterfly_o[2]),
        .A_addr_in(a_in[2]), .B_addr_in(b_in[2]),
        .rd_en(rd_en_o[2]), .wr_en(wr_en_o[2]),
        .wr_A_addr(wr_a_o[2]), .wr_B_addr(wr_b_o[2]),
        .busy(busy_o[2]), .done(done_o[2])
    );

    always #5 clk = ~clk;

    // Combinational LUT attached to each DUT.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            a_in[i] = lut_a[stage_o[i]][butterfly_o[i]];
            b_in[i] = lut_b[stage_o[i]][butterfly_o[i]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] obs(input int i);
        return {stage_o[i], butterfly_o[i], rd_en_o[i], wr_en_o[i],
                wr_a_o[i], wr_b_o[i], busy_o[i], done_o[i]};
    endfunction

    // Expected outputs from the schedule: stage s, butterfly b reads in run
    // cycle 1 + s*(8+L) + b, writes L cycles later, done in cycle 33 + 4L.
    function automatic logic [16:0] model_out(input int lat, input bit a, input int k);
        logic [1:0] s;
        logic [2:0] b;
        logic       rd, wr, bs, dn;
        logic [3:0] wa, wb;
        int         si, ri, j;
        s = 2'd0; b = 3'd0; rd = 1'b0; wr = 1'b0;
        bs = 1'b0; dn = 1'b0; wa = 4'd0; wb = 4'd0;
        if (a) begin
            if (k == 33 + 4*lat) begin
                dn = 1'b1; s = 2'd3; b = 3'd7;
            end else begin
                si = (k - 1) / (8 + lat);
                ri = (k - 1) % (8 + lat);
                s  = 2'(si);
                bs = 1'b1;
                if (ri < 8) begin
                    rd = 1'b1; b = 3'(ri);
                end else begin
                    b = 3'd7;
                end
                j = k - lat;
                if (j >= 1) begin
                    si = (j - 1) / (8 + lat);
                    ri = (j - 1) % (8 + lat);
                    if (ri < 8) begin
                        wr = 1'b1; wa = lut_a[si][ri]; wb = lut_b[si][ri];
                    end
                end
            end
        end
        return {s, b, rd, wr, wa, wb, bs, dn};
    endfunction

    // One clock cycle: drive start, compare mid-cycle, advance the model.
    task automatic tick(input bit st);
        @(posedge clk);
        #1 start = st;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("trace_L%0d_c%0d", lat_v[i], rel), 32'(obs(i)),
                  32'(model_out(lat_v[i], act[i], k_cyc[i])));
            if (done_o[i]) begin
                done_cnt[i]++;
                if (done_cnt[i] == 1) done_1st[i] = rel;
                if (done_cnt[i] == 2) done_2nd[i] = rel;
            end
            if (act[i]) begin
                if (k_cyc[i] == 33 + 4*lat_v[i]) act[i] = 1'b0;
                else k_cyc[i]++;
            end else if (st && !rst) begin
                act[i]   = 1'b1;
                k_cyc[i] = 1;
            end
        end
        rel++;
    endtask

    task automatic new_scenario();
        rel = 0;
        for (int i = 0; i < 3; i++) begin
            done_cnt[i] = 0; done_1st[i] = -1; done_2nd[i] = -1;
        end
    endtask

    // Let every instance return to idle, with a bounded cycle budget.
    task automatic wait_idle();
        bit any_act;
        any_act = 1'b0;
        for (int i = 0; i < 3; i++) any_act |= act[i];
        for (int n = 0; n < 200 && any_act; n++) begin
            tick(1'b0);
            any_act = 1'b0;
            for (int i = 0; i < 3; i++) any_act |= act[i];
        end
        tick(1'b0);
        check("idle_timeout", 32'(any_act), 32'd0);
    endtask

    // Asynchronous reset between edges: outputs must clear with no clock.
    task automatic async_reset_check(input string tag);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_L%0d", tag, lat_v[i]), 32'(obs(i)), 32'd0);
            act[i] = 1'b0;
        end
    endtask

    task automatic fill_real_lut();
        int h;
        logic [2:0] b;
        for (int s = 0; s < 4; s++) begin
            for (int bi = 0; bi < 8; bi++) begin
                b = 3'(bi);
                if (s == 0) begin
                    lut_a[s][bi] = {1'b0, b[0], b[1], b[2]};
                    lut_b[s][bi] = {1'b1, b[0], b[1], b[2]};
                end else begin
                    h = 8 >> s;
                    lut_a[s][bi] = 4'((bi / h) * 2 * h + (bi % h));
                    lut_b[s][bi] = 4'((bi / h) * 2 * h + (bi % h) + h);
                end
            end
        end
    endtask

    task automatic fill_random_lut();
        for (int s = 0; s < 4; s++) begin
            for (int bi = 0; bi < 8; bi++) begin
                lut_a[s][bi] = 4'($urandom);
                lut_b[s][bi] = 4'($urandom);
            end
        end
    endtask

    initial begin
        clk   = 1'b0;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            act[i] = 1'b0; k_cyc[i] = 0;
        end
        fill_real_lut();

        // Reset state before any clock edge, then 10 quiet cycles.
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_init_L%0d", lat_v[i]), 32'(obs(i)), 32'd0);
        end
        #11 rst = 1'b0;
        new_scenario();
        for (int n = 0; n < 10; n++) tick(1'b0);

        // Full run with the real in-place LUT.
        new_scenario();
        tick(1'b1);
        while (rel <= 70) tick(1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("full_done_cycle_L%0d", lat_v[i]), 32'(done_1st[i]), 32'(33 + 4*lat_v[i]));
            check($sformatf("full_done_count_L%0d", lat_v[i]), 32'(done_cnt[i]), 32'd1);
        end
        wait_idle();

        // start pulses while busy must be ignored.
        fill_random_lut();
        new_scenario();
        tick(1'b1);
        while (rel <= 70) begin
            tick(rel == 5 || rel == 20 || (rel <= 32 && $urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("busy_start_done_cycle_L%0d", lat_v[i]), 32'(done_1st[i]), 32'(33 + 4*lat_v[i]));
            check($sformatf("busy_start_done_count_L%0d", lat_v[i]), 32'(done_cnt[i]), 32'd1);
        end
        wait_idle();

        // Reset in cycle 15 mid-run, restart in cycle 20.
        fill_random_lut();
        new_scenario();
        tick(1'b1);
        while (rel <= 15) tick(1'b0);
        async_reset_check("rst_mid_run");
        tick(1'b0);
        tick(1'b0);
        #1 rst = 1'b0;
        while (rel < 20) tick(1'b0);
        tick(1'b1);
        while (rel <= 20 + 33 + 28 + 4) tick(1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("restart_done_cycle_L%0d", lat_v[i]), 32'(done_1st[i]), 32'(53 + 4*lat_v[i]));
            check($sformatf("restart_done_count_L%0d", lat_v[i]), 32'(done_cnt[i]), 32'd1);
        end
        wait_idle();

        // start held high: back-to-back runs with one idle cycle between.
        fill_real_lut();
        new_scenario();
        while (rel < 130) tick(1'b1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("held_done1_L%0d", lat_v[i]), 32'(done_1st[i]), 32'(33 + 4*lat_v[i]));
            check($sformatf("held_done2_L%0d", lat_v[i]), 32'(done_2nd[i]), 32'(67 + 8*lat_v[i]));
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
